// File: rtl/config_arbiter.sv
// config_arbiter: round-robin arbiter sharing the internal config-unit port
// between NREQ requesters. The winner is registered onto config_unit_*, and the
// bank response from the following cycle is routed back to that requester.
// Optional feature macro: CONFIG_ARB_GAP_EN inserts one idle cycle after every
// MAX_BURST consecutive issues, which lets OCP commands reach the bus.
module config_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_en,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [14*NREQ-1:0]   req_addr,
    input  logic [32*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_error,
    output logic                 config_unit_en,
    output logic                 config_unit_wr,
    output logic [13:0]          config_unit_addr,
    output logic [31:0]          config_unit_wdata,
    input  logic [31:0]          cfg_rdata,
    input  logic                 cfg_error
);

    localparam int unsigned IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_param_check
        $error("config_arbiter: NREQ or MAX_BURST out of range");
    end

    typedef enum logic {RUN, GAP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant, winner, pend_id, rsp_id;
    logic             found, issue, rsp_pend;
    logic             sel_wr;
    logic [13:0]      sel_addr;
    logic [31:0]      sel_wdata;

    // Round-robin search starting just above the last grant, plus winner's fields.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        found     = 1'b0;
        winner    = last_grant;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = (32'(last_grant) + off) % NREQ;
            if (!found && req_en[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_wr    = req_wr[i];
                sel_addr  = req_addr[i*14 +: 14];
                sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

`ifdef CONFIG_ARB_GAP_EN
    logic [3:0] burst_cnt, burst_d;

    // Next state and burst count: a forced GAP follows MAX_BURST back-to-back issues.
    always_comb begin
        state_d = state_q;
        burst_d = '0;
        issue   = 1'b0;
        case (state_q)
            RUN: begin
                issue = found;
                if (found) begin
                    burst_d = burst_cnt + 4'd1;
                    if (burst_d == 4'(MAX_BURST)) begin
                        state_d = GAP;
                    end
                end
            end
            GAP:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Burst counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_cnt <= '0;
        end else begin
            burst_cnt <= burst_d;
        end
    end
`else
    // Next state: without the gap feature the arbiter issues whenever anyone asks.
    always_comb begin
        state_d = RUN;
        issue   = 1'b0;
        case (state_q)
            RUN:     issue = found;
            default: issue = 1'b0;
        endcase
    end
`endif

    // Combinational one-hot grant, forced low while reset is held.
    always_comb begin
        req_ack = '0;
        if (reset && issue) begin
            req_ack = NREQ'(1) << winner;
        end
    end

    // FSM state, registered command and the id/valid pipeline for the response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= RUN;
            last_grant        <= IDW'(NREQ - 1);
            pend_id           <= '0;
            rsp_id            <= '0;
            rsp_pend          <= 1'b0;
            config_unit_en    <= 1'b0;
            config_unit_wr    <= 1'b0;
            config_unit_addr  <= '0;
            config_unit_wdata <= '0;
        end else begin
            state_q        <= state_d;
            config_unit_en <= issue;
            rsp_pend       <= config_unit_en;
            rsp_id         <= pend_id;
            if (issue) begin
                last_grant        <= winner;
                pend_id           <= winner;
                config_unit_wr    <= sel_wr;
                config_unit_addr  <= sel_addr;
                config_unit_wdata <= sel_wdata;
            end
        end
    end

    // Response routing: bank data arrives the cycle after config_unit_en.
    always_comb begin
        resp_valid = '0;
        resp_rdata = '0;
        resp_error = 1'b0;
        if (rsp_pend) begin
            resp_valid = NREQ'(1) << rsp_id;
            resp_rdata = cfg_rdata;
            resp_error = cfg_error;
        end
    end

endmodule
